csr_unit: RTL

Machine-mode CSR responder for the three-stage RV32I pipeline. Consumes the CSR write-enable and source-select produced by the decode/control logic and executes CSRRW/CSRRS/CSRRC and their immediate forms. Holds the `tohost` register used by the test harness and, when configured in, the 64-bit `cycle` and `instret` counters. Returns the old CSR value for writeback to `rd`.

---
 rtl/csr_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/csr_unit.sv
// ============================================================================
// csr_unit : machine-mode CSR responder (CSRRW/RS/RC and immediate forms).
// Optional 64-bit cycle/instret counters are built when CSR_COUNTERS_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module csr_unit #(
  parameter logic [11:0] TOHOST_ADDR = 12'h51E,
  parameter logic [31:0] TOHOST_RST  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic        csr_sel,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  src_idx,
  input  logic [31:0] rs1_data,
  input  logic        stall,
  input  logic        retire,
  output logic [31:0] csr_rdata,
  output logic [31:0] tohost,
  output logic        tohost_valid,
  output logic        illegal_csr
);

  localparam logic [1:0] OP_ILL = 2'b00;
  localparam logic [1:0] OP_RW  = 2'b01;
  localparam logic [1:0] OP_RS  = 2'b10;

  logic [1:0]  op;
  logic [31:0] src;
  logic        write_attempt;
  logic        hit_tohost;
  logic        ro_hit;
  logic [31:0] ro_val;
  logic        mapped;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        tohost_commit;
  logic [31:0] tohost_reg;
  logic        valid_reg;
  logic        unused_bits;

  assign op  = funct3[1:0];
  assign src = csr_sel ? rs1_data : {27'b0, src_idx};

  // RS/RC with a zero source index is a pure read and never a write attempt.
  assign write_attempt = (op == OP_RW) || (op[1] && (src_idx != 5'd0));

  assign hit_tohost = (csr_addr == TOHOST_ADDR);
  assign mapped     = hit_tohost || ro_hit;

  assign illegal_csr = csr_we && (!mapped || (op == OP_ILL) || (ro_hit && write_attempt));

  assign old_val   = hit_tohost ? tohost_reg : ro_val;
  assign csr_rdata = (csr_we && !illegal_csr) ? old_val : 32'h0;

  always_comb begin
    new_val = src;
    if (op == OP_RS)
      new_val = old_val | src;
    else if (op == 2'b11)
      new_val = old_val & ~src;
  end

  assign tohost_commit = csr_we && !stall && hit_tohost && !illegal_csr && write_attempt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tohost_reg <= TOHOST_RST;
      valid_reg  <= 1'b0;
    end else begin
      valid_reg <= tohost_commit;
      if (tohost_commit)
        tohost_reg <= new_val;
    end
  end

  assign tohost       = tohost_reg;
  assign tohost_valid = valid_reg;

`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH = 12'hC82;

  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;

  // cycle ignores stall; instret only counts unstalled retirements.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt   <= 64'd0;
      instret_cnt <= 64'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (retire && !stall)
        instret_cnt <= instret_cnt + 64'd1;
    end
  end

  always_comb begin
    ro_hit = 1'b1;
    ro_val = 32'h0;
    case (csr_addr)
      ADDR_CYCLE:    ro_val = cycle_cnt[31:0];
      ADDR_CYCLEH:   ro_val = cycle_cnt[63:32];
      ADDR_INSTRET:  ro_val = instret_cnt[31:0];
      ADDR_INSTRETH: ro_val = instret_cnt[63:32];
      default:       ro_hit = 1'b0;
    endcase
  end
`else
  assign ro_hit = 1'b0;
  assign ro_val = 32'h0;
`endif

  assign unused_bits = ^{funct3[2], retire};

endmodule

`default_nettype wire
